// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle IF/ID/EX/MEM/WB control FSM for the 16-bit
// AVR-subset core. It drives the fetch and data-memory handshakes and the
// register-file/PC strobes, and flags illegal opcodes and bus timeouts.
// Optional feature macro: SEQ_PERF_COUNTERS_EN enables the retired-instruction
// and cycle counters. When it is undefined, both counters read 0 and no
// counter flops are built.
// The opcode encodings normally come from defines.vh. The guarded fallbacks
// below keep this file self-contained.

`ifndef TYPE_UNKNOWN
`define TYPE_UNKNOWN     8'h00
`define TYPE_NOP         8'h01
`define TYPE_ADD         8'h02
`define TYPE_ADC         8'h03
`define TYPE_SUB         8'h04
`define TYPE_AND         8'h05
`define TYPE_OR          8'h06
`define TYPE_EOR         8'h07
`define TYPE_MOV         8'h08
`define TYPE_LDI         8'h09
`define TYPE_LDS         8'h0A
`define TYPE_LDD         8'h0B
`define TYPE_STS         8'h0C
`endif
`ifndef GROUP_DEFAULT
`define GROUP_DEFAULT    8'h00
`define GROUP_ARITHMETIC 8'h01
`define GROUP_REGISTER   8'h02
`define GROUP_MEMORY     8'h03
`endif

module instr_sequencer #(
    parameter int MEM_TIMEOUT   = 15,
    parameter int TIMEOUT_WIDTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 imem_ack,
    input  logic [7:0]           opcode_type,
    input  logic [7:0]           opcode_group,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 alu_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired_cnt,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_TRAP = 3'd7
    } state_t;

    state_t                   state_q;
    logic [TIMEOUT_WIDTH-1:0] wait_q;

    logic is_alu_grp;
    logic is_mem_grp;
    logic is_store;
    logic is_load;
    logic mem_expired;

    assign is_alu_grp  = (opcode_group == `GROUP_ARITHMETIC) || (opcode_group == `GROUP_REGISTER);
    assign is_mem_grp  = (opcode_group == `GROUP_MEMORY);
    assign is_store    = (opcode_type == `TYPE_STS);
    assign is_load     = (opcode_type == `TYPE_LDS) || (opcode_type == `TYPE_LDD);
    assign mem_expired = (wait_q == TIMEOUT_WIDTH'(MEM_TIMEOUT));

    // State register and MEM wait counter; stall only holds ID/EX/WB
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_IF;
                S_IF: begin
                    if (imem_ack) state_q <= S_ID;
                end
                S_ID: begin
                    if (!stall) begin
                        if (opcode_type == `TYPE_NOP)          state_q <= S_IF;
                        else if (opcode_type == `TYPE_UNKNOWN) state_q <= S_TRAP;
                        else if (is_alu_grp || is_mem_grp)     state_q <= S_EX;
                        else                                   state_q <= S_TRAP;
                    end
                end
                S_EX: begin
                    if (!stall) begin
                        if (is_mem_grp) begin
                            state_q <= S_MEM;
                            wait_q  <= '0;
                        end else if (is_alu_grp) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_TRAP;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_store)     state_q <= S_IF;
                        else if (is_load) state_q <= S_WB;
                        else              state_q <= S_TRAP;
                    end else if (mem_expired) begin
                        state_q <= S_TRAP;
                    end else begin
                        wait_q <= wait_q + TIMEOUT_WIDTH'(1);
                    end
                end
                S_WB: begin
                    if (!stall) state_q <= S_IF;
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore output decode; reset forces every output low in the same cycle
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        trap     = 1'b0;
        state    = 3'd0;
        if (reset) begin
            state = state_q;
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_ID:  pc_we  = !stall && (opcode_type == `TYPE_NOP);
                S_EX:  alu_en = !stall;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = dmem_ack && is_store;
                end
                S_WB: begin
                    rf_we = !stall;
                    pc_we = !stall;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] retired_q;

    // Performance counters: free-running cycles and retirements, frozen in TRAP
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else if (state_q != S_TRAP) begin
            cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (pc_we) retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    assign cycle_cnt   = reset ? cycle_q   : '0;
    assign retired_cnt = reset ? retired_q : '0;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer, using 4-bit counters so that
// counter wrap is reachable. Expected counter values follow
// SEQ_PERF_COUNTERS_EN.

`ifndef TYPE_UNKNOWN
`define TYPE_UNKNOWN     8'h00
`define TYPE_NOP         8'h01
`define TYPE_ADD         8'h02
`define TYPE_ADC         8'h03
`define TYPE_SUB         8'h04
`define TYPE_AND         8'h05
`define TYPE_OR          8'h06
`define TYPE_EOR         8'h07
`define TYPE_MOV         8'h08
`define TYPE_LDI         8'h09
`define TYPE_LDS         8'h0A
`define TYPE_LDD         8'h0B
`define TYPE_STS         8'h0C
`endif
`ifndef GROUP_DEFAULT
`define GROUP_DEFAULT    8'h00
`define GROUP_ARITHMETIC 8'h01
`define GROUP_REGISTER   8'h02
`define GROUP_MEMORY     8'h03
`endif

module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       imem_ack;
    logic [7:0] opcode_type;
    logic [7:0] opcode_group;
    logic       dmem_ack;
    logic       imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, trap;
    logic [2:0] state;
    logic [3:0] retired_cnt;
    logic [3:0] cycle_cnt;

    int total = 0;
    int bad   = 0;
    int ecyc  = 0;
    int eret  = 0;

    logic [2:0] st_log [0:63];
    logic       pc_log [0:63];
    int n_rf, n_pc, n_req, n_we, n_alu, n_ir;

    instr_sequencer #(
        .MEM_TIMEOUT  (15),
        .TIMEOUT_WIDTH(4),
        .CNT_WIDTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_ack    (imem_ack),
        .opcode_type (opcode_type),
        .opcode_group(opcode_group),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .ir_we       (ir_we),
        .alu_en      (alu_en),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .trap        (trap),
        .state       (state),
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ecnt(input int v);
`ifdef SEQ_PERF_COUNTERS_EN
        return 4'(v);
`else
        return 4'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles from the current edge, acking data at ack_idx and stalling over [s_lo, s_hi]
    task automatic run(input int n, input int ack_idx, input int s_lo, input int s_hi);
        n_rf = 0; n_pc = 0; n_req = 0; n_we = 0; n_alu = 0; n_ir = 0;
        for (int i = 0; i < n; i++) begin
            dmem_ack = (i == ack_idx);
            stall    = (i >= s_lo) && (i <= s_hi);
            #1;
            st_log[i] = state;
            pc_log[i] = pc_we;
            n_rf  += int'(rf_we);
            n_pc  += int'(pc_we);
            n_req += int'(dmem_req);
            n_we  += int'(dmem_we);
            n_alu += int'(alu_en);
            n_ir  += int'(ir_we);
            tick();
        end
        dmem_ack = 1'b0;
        stall    = 1'b0;
        ecyc += n;
    endtask

    task automatic chk_states(input string tag, input string s);
        for (int i = 0; i < s.len(); i++)
            chk($sformatf("%s_st%0d", tag, i), 32'(st_log[i]), 32'(s[i] - 8'd48));
    endtask

    // Pulse reset for one cycle, leave the FSM in IF with counters restarted
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_rst_state"}, 32'(state), 32'd0);
        chk({tag, "_rst_dreq"}, 32'(dmem_req), 32'd0);
        chk({tag, "_rst_trap"}, 32'(trap), 32'd0);
        chk({tag, "_rst_cyc"}, 32'(cycle_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        ecyc = 1;
        eret = 0;
        chk({tag, "_if"}, 32'(state), 32'd1);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode_type = `TYPE_NOP; opcode_group = `GROUP_DEFAULT;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d_state", i), 32'(state), 32'd0);
            chk($sformatf("rst%0d_imem_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("rst%0d_cyc", i), 32'(cycle_cnt), 32'd0);
        end

        // ADD with immediate fetch ack: IDLE, IF, ID, EX, WB, IF
        reset = 1'b1; imem_ack = 1'b1;
        opcode_type = `TYPE_ADD; opcode_group = `GROUP_ARITHMETIC;
        #1;
        chk("add_idle", 32'(state), 32'd0);
        tick();
        ecyc = 1;
        run(4, -1, -1, -1);
        chk_states("add", "1235");
        chk("add_next_if", 32'(state), 32'd1);
        chk("add_rf_we", n_rf, 1);
        chk("add_pc_we", n_pc, 1);
        chk("add_ir_we", n_ir, 1);
        chk("add_alu", n_alu, 1);
        eret = 1;
        chk("add_retired", 32'(retired_cnt), 32'(ecnt(eret)));
        chk("add_cycles", 32'(cycle_cnt), 32'(ecnt(ecyc)));

        // LDS with data ack on the fourth MEM cycle: 8 cycles IF to IF
        opcode_type = `TYPE_LDS; opcode_group = `GROUP_MEMORY;
        run(8, 6, -1, -1);
        chk_states("lds", "12344445");
        chk("lds_next_if", 32'(state), 32'd1);
        chk("lds_dmem_req", n_req, 4);
        chk("lds_dmem_we", n_we, 0);
        chk("lds_rf_we", n_rf, 1);
        eret = 2;

        // MOV stalled two cycles in EX: 6 cycles, one alu_en, one rf_we
        opcode_type = `TYPE_MOV; opcode_group = `GROUP_REGISTER;
        run(6, -1, 2, 3);
        chk_states("mov", "123335");
        chk("mov_alu", n_alu, 1);
        chk("mov_rf_we", n_rf, 1);
        chk("mov_pc_we", n_pc, 1);
        eret = 3;
        chk("mov_retired", 32'(retired_cnt), 32'(ecnt(eret)));
        chk("mov_cycles", 32'(cycle_cnt), 32'(ecnt(ecyc)));

        // STS with zero-wait ack: 4 cycles, retires from MEM
        opcode_type = `TYPE_STS; opcode_group = `GROUP_MEMORY;
        run(4, 3, -1, -1);
        chk_states("sts", "1234");
        chk("sts_next_if", 32'(state), 32'd1);
        chk("sts_dmem_we", n_we, 1);
        chk("sts_pc_we", n_pc, 1);
        chk("sts_rf_we", n_rf, 0);
        eret = 4;

        // Fetch waits without ack; stall is ignored in IF
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        chk("ifw_req", 32'(imem_req), 32'd1);
        chk("ifw_ir_we", 32'(ir_we), 32'd0);
        tick();
        chk("ifw_state1", 32'(state), 32'd1);
        tick();
        chk("ifw_state2", 32'(state), 32'd1);
        ecyc += 2;
        imem_ack = 1'b1; stall = 1'b0;

        // STS with no ack: 16 MEM cycles with dmem_we, then TRAP held
        run(19, -1, -1, -1);
        chk_states("sto", "1234444444444444444");
        chk("sto_dmem_req", n_req, 16);
        chk("sto_dmem_we", n_we, 16);
        chk("sto_pc_we", n_pc, 0);
        chk("sto_state", 32'(state), 32'd7);
        chk("sto_trap", 32'(trap), 32'd1);
        chk("sto_dreq_off", 32'(dmem_req), 32'd0);
        tick();
        tick();
        chk("sto_hold_state", 32'(state), 32'd7);
        chk("sto_hold_trap", 32'(trap), 32'd1);
        chk("sto_frozen_cyc", 32'(cycle_cnt), 32'(ecnt(ecyc)));
        chk("sto_frozen_ret", 32'(retired_cnt), 32'(ecnt(eret)));

        // Reset out of TRAP, then a NOP stream exercising counter wrap
        opcode_type = `TYPE_NOP; opcode_group = `GROUP_DEFAULT;
        do_reset("trap");
        run(30, -1, -1, -1);
        for (int i = 0; i < 30; i++)
            chk($sformatf("nop_pc%0d", i), 32'(pc_log[i]), 32'(i % 2));
        eret = 15;
        chk("nop15_retired", 32'(retired_cnt), 32'(ecnt(eret)));
        chk("nop15_cycles", 32'(cycle_cnt), 32'(ecnt(ecyc)));
        run(2, -1, -1, -1);
        eret = 16;
        chk_states("nop16", "12");
        chk("nop16_retired_wrap", 32'(retired_cnt), 32'(ecnt(eret)));
        chk("nop16_cycles_wrap", 32'(cycle_cnt), 32'(ecnt(ecyc)));

        // LDS abandoned in MEM by reset: request drops in the same cycle
        opcode_type = `TYPE_LDS; opcode_group = `GROUP_MEMORY;
        run(4, -1, -1, -1);
        chk("abort_in_mem", 32'(state), 32'd4);
        chk("abort_dreq_before", 32'(dmem_req), 32'd1);
        do_reset("abort");

        // Unknown opcode traps from ID without retiring
        opcode_type = `TYPE_UNKNOWN; opcode_group = `GROUP_DEFAULT;
        run(2, -1, -1, -1);
        chk_states("unk", "12");
        chk("unk_state", 32'(state), 32'd7);
        chk("unk_trap", 32'(trap), 32'd1);
        chk("unk_pc_we", n_pc, 0);
        chk("unk_retired", 32'(retired_cnt), 32'(ecnt(0)));

        // Known type in the default group also traps
        do_reset("dflt");
        opcode_type = `TYPE_ADD; opcode_group = `GROUP_DEFAULT;
        run(2, -1, -1, -1);
        chk("dflt_state", 32'(state), 32'd7);
        chk("dflt_alu", n_alu, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
